servo_pwm_ramp: RTL and testbench

SERVO_PWM_RAMP -- requirements
Module: servo_pwm_ramp

---
 rtl/servo_pkg.sv | 28 ++
 rtl/servo_slew_channel.sv | 63 ++++++
 rtl/servo_pwm_ramp.sv | 106 ++++++++++
 tb/tb_servo_pwm_ramp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared timing defaults for the servo PWM block, plus the pulse-width clamp
// used by the write decoder.
package servo_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 25_000_000;
  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_PERIOD_CLKS = 500_000;
  localparam int unsigned DEF_MIN_PULSE   = 25_000;
  localparam int unsigned DEF_MAX_PULSE   = 50_000;
  localparam int unsigned DEF_RESET_PULSE = 25_000;
  localparam int unsigned DEF_STEP_CLKS   = 250;
  localparam int unsigned DEF_CNT_W       = 19;

  // Limits a requested width to the mechanically safe range of the servo.
  function automatic logic [31:0] clamp_pulse(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] result;
    result = value;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: holds the target and the slew-limited active width, and
// produces the registered PWM output from the shared frame counter.
module servo_slew_channel #(
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned RESET_PULSE = 25_000,
  parameter int unsigned STEP_CLKS   = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_value,
  input  logic             enable,
  output logic             pwm_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RESET_W = CNT_W'(RESET_PULSE);
  localparam logic [CNT_W-1:0] STEP_W  = CNT_W'(STEP_CLKS);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  // The boundary update reads target_q, so a write landing on the same cycle
  // only takes effect from the following frame.
  always_comb begin
    target_d = target_q;
    active_d = active_q;
    pwm_d    = enable && (cnt < active_q);

    if (wr_en) begin
      target_d = wr_value;
    end

    if (boundary) begin
      if (STEP_CLKS == 0) begin
        active_d = target_q;
      end else if (target_q > active_q) begin
        active_d = ((target_q - active_q) <= STEP_W) ? target_q : (active_q + STEP_W);
      end else begin
        active_d = ((active_q - target_q) <= STEP_W) ? target_q : (active_q - STEP_W);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= RESET_W;
      active_q <= RESET_W;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign busy    = (active_q != target_q);

endmodule

// File: rtl/servo_pwm_ramp.sv
// Multi-channel servo PWM generator with per-frame slew limiting. The frame
// counter and write decode live here; each channel is a servo_slew_channel.
module servo_pwm_ramp
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned PERIOD_CLKS = DEF_PERIOD_CLKS,
  parameter int unsigned MIN_PULSE   = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE   = DEF_MAX_PULSE,
  parameter int unsigned RESET_PULSE = DEF_RESET_PULSE,
  parameter int unsigned STEP_CLKS   = DEF_STEP_CLKS,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [CNT_W-1:0]                          wr_target,
  input  logic [NUM_CH-1:0]                         ch_enable,
  output logic                                      wr_ack,
  output logic                                      wr_err,
  output logic [NUM_CH-1:0]                         servo_pwm_out,
  output logic [NUM_CH-1:0]                         ch_busy,
  output logic                                      frame_start
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CLKS - 1);

  // Reject parameter sets that cannot produce a sensible frame.
  if (CLK_FREQ_HZ == 0) begin : g_bad_clk
    $error("servo_pwm_ramp: CLK_FREQ_HZ must be non-zero");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_pwm_ramp: NUM_CH must be 1..16");
  end
  if (CNT_W > 32 || (64'(1) << CNT_W) <= 64'(PERIOD_CLKS)) begin : g_bad_cnt_w
    $error("servo_pwm_ramp: CNT_W too small for PERIOD_CLKS or above 32");
  end
  if (MIN_PULSE > MAX_PULSE || MAX_PULSE >= PERIOD_CLKS ||
      RESET_PULSE < MIN_PULSE || RESET_PULSE > MAX_PULSE) begin : g_bad_pulse
    $error("servo_pwm_ramp: pulse limits inconsistent");
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              boundary;
  logic              wr_valid;
  logic [CNT_W-1:0]  wr_value;
  logic [NUM_CH-1:0] ch_wr;

  // frame_start registers (counter == 0) so it lines up with the first high
  // PWM cycle, which carries the same one-clock latency.
  always_comb begin
    boundary      = (cnt_q == LAST_CNT);
    cnt_d         = boundary ? '0 : (cnt_q + CNT_W'(1));
    wr_valid      = wr_en && (32'(wr_ch) < NUM_CH);
    wr_value      = CNT_W'(clamp_pulse(32'(wr_target), MIN_PULSE, MAX_PULSE));
    frame_start_d = (cnt_q == '0);
    wr_ack_d      = wr_valid;
    wr_err_d      = wr_en && !wr_valid;
    ch_wr         = '0;
    if (wr_valid) begin
      ch_wr[wr_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      wr_ack_q      <= wr_ack_d;
      wr_err_q      <= wr_err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_channel #(
      .CNT_W      (CNT_W),
      .RESET_PULSE(RESET_PULSE),
      .STEP_CLKS  (STEP_CLKS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .cnt     (cnt_q),
      .boundary(boundary),
      .wr_en   (ch_wr[i]),
      .wr_value(wr_value),
      .enable  (ch_enable[i]),
      .pwm_out (servo_pwm_out[i]),
      .busy    (ch_busy[i])
    );
  end

  assign frame_start = frame_start_q;
  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Directed bench for servo_pwm_ramp using a shortened frame (200 clocks,
// pulses 50..100, step 5) with three channels so wr_ch=3 is out of range.
module tb_servo_pwm_ramp;

  localparam int NUM_CH = 3;
  localparam int P      = 200;
  localparam int MIN_P  = 50;
  localparam int MAX_P  = 100;
  localparam int RST_P  = 50;
  localparam int STEP   = 5;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [CNT_W-1:0]  wr_target = '0;
  logic [NUM_CH-1:0] ch_enable = '1;
  logic              wr_ack, wr_err, frame_start;
  logic [NUM_CH-1:0] servo_pwm_out, ch_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hi_cnt[NUM_CH];
  int fs_cnt, fs_idx;

  servo_pwm_ramp #(
    .CLK_FREQ_HZ(25_000_000),
    .NUM_CH     (NUM_CH),
    .PERIOD_CLKS(P),
    .MIN_PULSE  (MIN_P),
    .MAX_PULSE  (MAX_P),
    .RESET_PULSE(RST_P),
    .STEP_CLKS  (STEP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_target    (wr_target),
    .ch_enable    (ch_enable),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .servo_pwm_out(servo_pwm_out),
    .ch_busy      (ch_busy),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // cyc counts edges since reset release, so cyc % P is the DUT counter value.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align_to(input int phase);
    while ((cyc % P) != phase) tick();
  endtask

  task automatic set_write(input int ch, input int target);
    wr_en     = 1'b1;
    wr_ch     = 2'(ch);
    wr_target = CNT_W'(target);
  endtask

  // Runs one full frame from counter 0; drops any pending write after the first edge.
  task automatic measure_frame();
    fs_cnt = 0;
    fs_idx = -1;
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (i == 0) wr_en = 1'b0;
      if (frame_start) begin
        fs_cnt++;
        fs_idx = i;
      end
      for (int c = 0; c < NUM_CH; c++) if (servo_pwm_out[c]) hi_cnt[c]++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (servo_pwm_out !== 3'b000) begin failures++; $display("[TB] FAIL reset_pwm: got %b expected 000", servo_pwm_out); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if ({wr_ack, wr_err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ack_err: got %b expected 00", {wr_ack, wr_err}); end
    checks++; if (ch_busy !== 3'b000) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 000", ch_busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    tick();
    checks++; if (frame_start !== 1'b1) begin failures++; $display("[TB] FAIL first_frame_start: got %b expected 1", frame_start); end
    checks++; if (servo_pwm_out !== 3'b111) begin failures++; $display("[TB] FAIL first_pwm_high: got %b expected 111", servo_pwm_out); end
  endtask

  task automatic test_default_frame();
    align_to(0);
    measure_frame();
    for (int c = 0; c < NUM_CH; c++) begin
      checks++; if (hi_cnt[c] != RST_P) begin failures++; $display("[TB] FAIL default_width ch%0d: got %0d expected %0d", c, hi_cnt[c], RST_P); end
    end
    checks++; if (fs_cnt != 1 || fs_idx != 0) begin failures++; $display("[TB] FAIL default_frame_start: got count %0d at %0d expected 1 at 0", fs_cnt, fs_idx); end
  endtask

  task automatic test_slew();
    int exp_w;
    align_to(5);
    set_write(1, 75);
    tick();
    wr_en = 1'b0;
    checks++; if ({wr_ack, wr_err} !== 2'b10) begin failures++; $display("[TB] FAIL slew_ack: got %b expected 10", {wr_ack, wr_err}); end
    checks++; if (ch_busy !== 3'b010) begin failures++; $display("[TB] FAIL slew_busy_set: got %b expected 010", ch_busy); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL slew_ack_pulse: got %b expected 0", wr_ack); end
    align_to(0);
    for (int k = 0; k < 5; k++) begin
      measure_frame();
      exp_w = 55 + 5 * k;
      checks++; if (hi_cnt[1] != exp_w) begin failures++; $display("[TB] FAIL slew_width frame%0d: got %0d expected %0d", k, hi_cnt[1], exp_w); end
      checks++; if (ch_busy[1] !== (exp_w + 5 < 75)) begin failures++; $display("[TB] FAIL slew_busy frame%0d: got %b expected %b", k, ch_busy[1], (exp_w + 5 < 75)); end
      if (k == 0) begin
        checks++; if (hi_cnt[0] != RST_P) begin failures++; $display("[TB] FAIL slew_other_ch: got %0d expected %0d", hi_cnt[0], RST_P); end
      end
    end
  endtask

  task automatic test_clamp_and_err();
    set_write(0, 10);
    tick();
    wr_en = 1'b0;
    checks++; if (ch_busy[0] !== 1'b0) begin failures++; $display("[TB] FAIL clamp_low_busy: got %b expected 0", ch_busy[0]); end
    set_write(0, 250);
    tick();
    wr_en = 1'b0;
    checks++; if (ch_busy[0] !== 1'b1) begin failures++; $display("[TB] FAIL clamp_high_busy: got %b expected 1", ch_busy[0]); end
    align_to(0);
    repeat (9) measure_frame();
    measure_frame();
    checks++; if (hi_cnt[0] != MAX_P) begin failures++; $display("[TB] FAIL clamp_high_width: got %0d expected %0d", hi_cnt[0], MAX_P); end
    checks++; if (hi_cnt[1] != 75) begin failures++; $display("[TB] FAIL settled_ch1: got %0d expected 75", hi_cnt[1]); end
    set_write(0, 10);
    tick();
    wr_en = 1'b0;
    align_to(0);
    measure_frame();
    checks++; if (hi_cnt[0] != 95) begin failures++; $display("[TB] FAIL slew_down_width: got %0d expected 95", hi_cnt[0]); end
    set_write(3, 90);
    tick();
    wr_en = 1'b0;
    checks++; if ({wr_ack, wr_err} !== 2'b01) begin failures++; $display("[TB] FAIL bad_ch_err: got ack/err %b expected 01", {wr_ack, wr_err}); end
    checks++; if (ch_busy !== 3'b001) begin failures++; $display("[TB] FAIL bad_ch_no_change: got %b expected 001", ch_busy); end
    tick();
    checks++; if (wr_err !== 1'b0) begin failures++; $display("[TB] FAIL bad_ch_err_pulse: got %b expected 0", wr_err); end
  endtask

  task automatic test_boundary_write();
    align_to(P - 1);
    set_write(2, 100);
    tick();
    wr_en = 1'b0;
    checks++; if (ch_busy[2] !== 1'b1) begin failures++; $display("[TB] FAIL boundary_busy: got %b expected 1", ch_busy[2]); end
    measure_frame();
    checks++; if (hi_cnt[2] != 50) begin failures++; $display("[TB] FAIL boundary_old_target: got %0d expected 50", hi_cnt[2]); end
    set_write(2, 50);
    measure_frame();
    checks++; if (hi_cnt[2] != 55) begin failures++; $display("[TB] FAIL boundary_next_step: got %0d expected 55", hi_cnt[2]); end
    checks++; if (ch_busy[2] !== 1'b0) begin failures++; $display("[TB] FAIL boundary_settle_busy: got %b expected 0", ch_busy[2]); end
  endtask

  task automatic test_back_to_back();
    align_to(10);
    set_write(1, 90);
    tick();
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ack1: got %b expected 1", wr_ack); end
    set_write(1, 60);
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ack2: got %b expected 1", wr_ack); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ack_end: got %b expected 0", wr_ack); end
    align_to(0);
    measure_frame();
    checks++; if (hi_cnt[1] != 70) begin failures++; $display("[TB] FAIL b2b_last_wins: got %0d expected 70", hi_cnt[1]); end
  endtask

  task automatic test_enable();
    int hi2;
    hi2 = 0;
    align_to(0);
    for (int i = 0; i < P; i++) begin
      if (i == 20) ch_enable = 3'b011;
      if (i == 50) set_write(2, 60);
      if (i == 51) wr_en = 1'b0;
      if (i == P - 1) ch_enable = 3'b111;
      tick();
      if (servo_pwm_out[2]) hi2++;
      if (i == 19) begin
        checks++; if (servo_pwm_out[2] !== 1'b1) begin failures++; $display("[TB] FAIL enable_before_drop: got %b expected 1", servo_pwm_out[2]); end
      end
      if (i == 20) begin
        checks++; if (servo_pwm_out[2:1] !== 2'b01) begin failures++; $display("[TB] FAIL enable_drop: got %b expected 01", servo_pwm_out[2:1]); end
      end
    end
    checks++; if (hi2 != 20) begin failures++; $display("[TB] FAIL enable_cut_width: got %0d expected 20", hi2); end
    checks++; if (ch_busy[2] !== 1'b1) begin failures++; $display("[TB] FAIL enable_slew_busy: got %b expected 1", ch_busy[2]); end
    measure_frame();
    checks++; if (hi_cnt[2] != 55) begin failures++; $display("[TB] FAIL reenable_width: got %0d expected 55", hi_cnt[2]); end
  endtask

  task automatic test_reset_mid_slew();
    align_to(10);
    set_write(0, 100);
    tick();
    wr_en = 1'b0;
    checks++; if (ch_busy[0] !== 1'b1 || servo_pwm_out[0] !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_state: got busy %b pwm %b expected 1 1", ch_busy[0], servo_pwm_out[0]); end
    reset = 1'b1;
    #1;
    checks++; if (servo_pwm_out !== 3'b000 || frame_start !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_out: got pwm %b fs %b expected 000 0", servo_pwm_out, frame_start); end
    checks++; if (ch_busy !== 3'b000) begin failures++; $display("[TB] FAIL async_reset_busy: got %b expected 000", ch_busy); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    measure_frame();
    for (int c = 0; c < NUM_CH; c++) begin
      checks++; if (hi_cnt[c] != RST_P) begin failures++; $display("[TB] FAIL post_reset_width ch%0d: got %0d expected %0d", c, hi_cnt[c], RST_P); end
    end
    checks++; if (fs_cnt != 1 || fs_idx != 0) begin failures++; $display("[TB] FAIL post_reset_frame_start: got count %0d at %0d expected 1 at 0", fs_cnt, fs_idx); end
    checks++; if (ch_busy !== 3'b000) begin failures++; $display("[TB] FAIL post_reset_busy: got %b expected 000", ch_busy); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_slew();
    test_clamp_and_err();
    test_boundary_write();
    test_back_to_back();
    test_enable();
    test_reset_mid_slew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
